// File: rtl/fft_frame_buffer.sv
// Collects a stream of signed samples into one flattened frame and holds the last complete frame for the FFT.
// Optional 50% frame overlap when FFT_FRAME_OVERLAP_EN is defined; the default build emits disjoint frames.
module fft_frame_buffer #(
    parameter int SAMPLE_SIZE = 32,
    parameter int BUFFER_SIZE = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SAMPLE_SIZE-1:0]             in_sample,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               flush,
    output logic [SAMPLE_SIZE*BUFFER_SIZE-1:0] frame_data,
    output logic                               frame_valid,
    input  logic                               frame_ready,
    output logic [15:0]                        frame_count
);

    localparam int CW  = $clog2(BUFFER_SIZE) + 1;
    localparam int AW  = $clog2(BUFFER_SIZE);
    localparam int HOP = BUFFER_SIZE / 2;
    localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0] LAST = CW'(BUFFER_SIZE - 1);

    logic [CW-1:0] count, count_d;
    logic [BUFFER_SIZE-1:0][SAMPLE_SIZE-1:0] cbuf_q, cbuf_w, cbuf_d;
    logic accept, full_next, transfer;

    assign in_ready  = (count < FULL) && !flush;
    assign accept    = in_valid && in_ready;
    assign full_next = (count == FULL) || (accept && (count == LAST));
    assign transfer  = full_next && (!frame_valid || frame_ready);

    // cbuf_w includes the sample accepted this edge, so a transfer never misses it
    always_comb begin
        cbuf_w  = cbuf_q;
        if (accept) begin
            cbuf_w[count[AW-1:0]] = in_sample;
        end
        cbuf_d  = cbuf_w;
        count_d = count;
        if (transfer) begin
`ifdef FFT_FRAME_OVERLAP_EN
            for (int i = 0; i < HOP; i++) begin
                cbuf_d[i] = cbuf_w[i + HOP];
            end
            count_d = CW'(HOP);
`else
            count_d = '0;
`endif
        end else if (flush) begin
            count_d = '0;
        end else if (accept) begin
            count_d = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            cbuf_q      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            count  <= count_d;
            cbuf_q <= cbuf_d;
            if (transfer) begin
                frame_data  <= cbuf_w;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Upstream stage of FFT_Top: collects a streaming sequence of signed audio samples into one flattened frame of BUFFER_SIZE samples and presents it as the FFT input bitstream.
- Sample k of a frame sits at frame_data[k*SAMPLE_SIZE +: SAMPLE_SIZE]; sample 0 is the first sample accepted.
- One collection buffer plus one output holding register, so collection of frame n+1 overlaps consumption of frame n.

Parameters:
- SAMPLE_SIZE, 32, width of one signed sample in bits.
- BUFFER_SIZE, 32, samples per frame; power of two, minimum 4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_sample  in  SAMPLE_SIZE  signed input sample.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  block accepts a sample this cycle.
- flush  in  1  synchronous pulse: discard the partial frame.
- frame_data  out  SAMPLE_SIZE*BUFFER_SIZE  flattened frame, FFT input bitstream.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_ready  in  1  downstream consumes the frame this cycle.
- frame_count  out  16  number of frames handed off; wraps at 65535 to 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset: count=0, frame_valid=0, frame_data=0, frame_count=0, collection buffer=0. Reset mid-frame discards the partial frame and any held frame.
- count: fill level of the collection buffer, width $clog2(BUFFER_SIZE)+1.
- in_ready (combinational): (count < BUFFER_SIZE) && !flush.
- Accept: in_valid && in_ready. The sample is written at slot count, and count increments.
- Transfer condition: the buffer becomes or is full (the accept brings count to BUFFER_SIZE, or count==BUFFER_SIZE already) and the output slot is free (!frame_valid || frame_ready). On transfer:
  - frame_data <= buffer, including the sample accepted this same edge.
  - frame_valid <= 1.
  - frame_count increments.
  - count <= 0.
- Latency: frame_valid is high in the cycle after the last sample of a frame is accepted, when the slot is free.
- Full buffer, output slot occupied: count holds at BUFFER_SIZE and in_ready=0 (backpressure). Transfer happens on the edge where frame_ready is seen; in_ready returns high the following cycle.
- Handshake: frame_valid && frame_ready consumes the frame. frame_valid falls next cycle unless a transfer occurs on the same edge, in which case it stays 1 with the new data.
- frame_data is stable while frame_valid=1 and frame_ready=0.
- flush: count <= 0. Does not affect frame_valid, frame_data or frame_count. If a transfer condition (count==BUFFER_SIZE) exists in the same cycle, the transfer wins and flush is ignored.
- No sample is ever dropped or duplicated while rst_n=1 and flush=0.
- Samples are stored bit-exact; no arithmetic is performed on them.

Optional Feature:
- Macro: FFT_FRAME_OVERLAP_EN.
- Defined: 50% overlap; hop size H = BUFFER_SIZE/2.
  - On transfer, buffer slots [0..H-1] <= slots [H..BUFFER_SIZE-1] of the frame just emitted, and count <= H.
  - Each subsequent frame therefore needs H new samples.
  - The first frame after reset or flush still needs BUFFER_SIZE samples.
  - flush returns to count=0, with no overlap retained.
- Undefined: frames do not overlap; count <= 0 on transfer.

Test Plan:
- Basic fill: frame_ready=1; stream samples 1..32 one per cycle → frame_valid=1 exactly one cycle after sample 32. frame_data[k*32 +: 32] = k+1 for all k; frame_count=1; in_ready never low.
- Back-to-back: stream 1..96 continuously with frame_ready=1 → three frames, starting 1, 33 and 65; frame_count=3; no input stall.
- Backpressure: frame_ready=0; stream 1..64 → first frame held stable. in_ready=0 after sample 64 is accepted into the full buffer. Raise frame_ready for one cycle → frame_data switches to 33..64 with frame_valid still 1, and in_ready=1 next cycle.
- Flush: send 1..10, pulse flush, then send 100..131 → frame contains 100..131 only, in order; frame_count=1.
- Reset mid-operation: held frame valid plus 5 samples buffered; assert rst_n=0 asynchronously between edges → frame_valid=0, frame_count=0 and in_ready=1 immediately, before the next edge. After release, the next frame starts from the first new sample.
- Overlap (FFT_FRAME_OVERLAP_EN defined): stream 1..64 with frame_ready=1 → frames emitted after samples 32, 48 and 64. Contents are 1..32, 17..48 and 33..64.
